isp_gain_stream: RTL and testbench

ISP_GAIN_STREAM -- requirements
Module: isp_gain_stream

---
 rtl/isp_gain_stream_pkg.sv | 38 +++
 rtl/isp_gain_stream_sat.sv | 43 ++++
 rtl/isp_gain_stream.sv | 239 +++++++++++++++++++++++
 tb/tb_isp_gain_stream.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_gain_stream_pkg.sv
// Shared types and constants for the Bayer gain stream: channel/CFA enums,
// Q2.8 gain constants, statistics width and the CFA channel lookup.
package isp_gain_stream_pkg;

    typedef enum logic [1:0] {
        CHAN_R = 2'd0,
        CHAN_G = 2'd1,
        CHAN_B = 2'd2
    } chan_t;

    typedef enum logic [1:0] {
        BAYER_RGGB = 2'd0,
        BAYER_GRBG = 2'd1,
        BAYER_GBRG = 2'd2,
        BAYER_BGGR = 2'd3
    } bayer_t;

    localparam int FRAC_BITS = 8;
    localparam int Q28_UNITY = 256;

    function automatic int stat_width(input int pix_w, input int line_length, input int frame_lines);
        return pix_w + $clog2(line_length * frame_lines);
    endfunction

    // Bit 1 of the CFA code is the row parity of R, bit 0 its column parity;
    // B sits diagonally opposite and the remaining two sites are green.
    function automatic chan_t chan_of(input bayer_t bayer, input logic row0, input logic col0);
        logic [1:0] code;
        code = bayer;
        if (row0 == code[1] && col0 == code[0]) begin
            return CHAN_R;
        end else if (row0 != code[1] && col0 != code[0]) begin
            return CHAN_B;
        end
        return CHAN_G;
    endfunction

endpackage

// File: rtl/isp_gain_stream_sat.sv
// isp_gain_sat: Q2.8 multiply, round-half-up, saturate to PIX_W, one output register.
module isp_gain_sat
    import isp_gain_stream_pkg::*;
#(
    parameter int PIX_W  = 10,
    parameter int GAIN_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [PIX_W-1:0]  pix_i,
    input  logic [GAIN_W-1:0] gain_i,
    output logic [PIX_W-1:0]  pix_o
);
    localparam int PROD_W = PIX_W + GAIN_W;
    localparam int SH_W   = PROD_W + 1 - FRAC_BITS;
    localparam logic [SH_W-1:0] MAX_SH = (SH_W'(1) << PIX_W) - SH_W'(1);

    logic [PROD_W-1:0] prod;
    logic [PROD_W:0]   rounded;
    logic [SH_W-1:0]   shifted;
    logic [PIX_W-1:0]  pix_d;
    logic [PIX_W-1:0]  pix_q;

    // One spare bit above the product keeps the rounding add from wrapping.
    always_comb begin
        prod    = PROD_W'(pix_i) * PROD_W'(gain_i);
        rounded = {1'b0, prod} + (PROD_W + 1)'(1 << (FRAC_BITS - 1));
        shifted = rounded[PROD_W:FRAC_BITS];
        pix_d   = (shifted > MAX_SH) ? MAX_SH[PIX_W-1:0] : shifted[PIX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q <= '0;
        end else if (en_i) begin
            pix_q <= pix_d;
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/isp_gain_stream.sv
// Per-channel white-balance gain on a raw Bayer stream with line/frame tracking.
// Optional per-frame channel sums are built when ISP_GAIN_STATS_EN is defined.
module isp_gain_stream
    import isp_gain_stream_pkg::*;
#(
    parameter int PIX_W       = 10,
    parameter int LINE_LENGTH = 640,
    parameter int FRAME_LINES = 480,
    parameter int BAYER       = 0,
    parameter int GAIN_W      = 10,
    localparam int STAT_W     = stat_width(PIX_W, LINE_LENGTH, FRAME_LINES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_pix,
    input  logic              in_sof,
    input  logic              in_eol,
    input  logic [GAIN_W-1:0] gain_r,
    input  logic [GAIN_W-1:0] gain_g,
    input  logic [GAIN_W-1:0] gain_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pix,
    output logic              out_sof,
    output logic              out_eol,
    output logic [1:0]        out_chan,
    output logic              err_short,
    output logic              err_long,
    output logic [STAT_W-1:0] stat_r,
    output logic [STAT_W-1:0] stat_g,
    output logic [STAT_W-1:0] stat_b,
    output logic              stat_valid
);
    localparam int COL_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam int ROW_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

    logic advance, accept, s2_load;
    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;
    logic at_last_col, at_last_row, line_end;
    logic [GAIN_W-1:0] gain_r_q, gain_g_q, gain_b_q;
    logic [GAIN_W-1:0] eff_r, eff_g, eff_b, gain_sel;
    logic err_short_q, err_short_d, err_long_q, err_long_d;
    chan_t chan_in;

    logic              s1_valid_q, s1_sof_q, s1_eol_q;
    logic [PIX_W-1:0]  s1_pix_q;
    logic [GAIN_W-1:0] s1_gain_q;
    chan_t             s1_chan_q;
    logic              s2_valid_q, s2_sof_q, s2_eol_q;
    chan_t             s2_chan_q;

    assign advance  = !s2_valid_q || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;
    assign s2_load  = advance && s1_valid_q;

    // A start-of-frame pixel sees col/row 0 and the fresh gains in the same cycle.
    always_comb begin
        cur_col     = in_sof ? '0 : col_q;
        cur_row     = in_sof ? '0 : row_q;
        at_last_col = (cur_col == COL_W'(LINE_LENGTH - 1));
        at_last_row = (cur_row == ROW_W'(FRAME_LINES - 1));
        line_end    = in_eol || at_last_col;
        eff_r       = in_sof ? gain_r : gain_r_q;
        eff_g       = in_sof ? gain_g : gain_g_q;
        eff_b       = in_sof ? gain_b : gain_b_q;
        chan_in     = chan_of(bayer_t'(2'(BAYER)), cur_row[0], cur_col[0]);
        case (chan_in)
            CHAN_R:  gain_sel = eff_r;
            CHAN_B:  gain_sel = eff_b;
            default: gain_sel = eff_g;
        endcase
        col_d       = col_q;
        row_d       = row_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        if (accept) begin
            err_short_d = in_eol && !at_last_col;
            err_long_d  = !in_eol && at_last_col;
            if (line_end) begin
                col_d = '0;
                row_d = at_last_row ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            gain_r_q    <= GAIN_W'(Q28_UNITY);
            gain_g_q    <= GAIN_W'(Q28_UNITY);
            gain_b_q    <= GAIN_W'(Q28_UNITY);
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            if (accept) begin
                gain_r_q <= eff_r;
                gain_g_q <= eff_g;
                gain_b_q <= eff_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_gain_q  <= '0;
            s1_chan_q  <= CHAN_R;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_chan_q  <= CHAN_R;
            s2_sof_q   <= 1'b0;
            s2_eol_q   <= 1'b0;
        end else begin
            if (advance) begin
                s1_valid_q <= in_valid;
                s2_valid_q <= s1_valid_q;
            end
            if (accept) begin
                s1_pix_q  <= in_pix;
                s1_gain_q <= gain_sel;
                s1_chan_q <= chan_in;
                s1_sof_q  <= in_sof;
                s1_eol_q  <= line_end;
            end
            if (s2_load) begin
                s2_chan_q <= s1_chan_q;
                s2_sof_q  <= s1_sof_q;
                s2_eol_q  <= s1_eol_q;
            end
        end
    end

    isp_gain_sat #(
        .PIX_W  (PIX_W),
        .GAIN_W (GAIN_W)
    ) u_sat (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (s2_load),
        .pix_i  (s1_pix_q),
        .gain_i (s1_gain_q),
        .pix_o  (out_pix)
    );

    assign out_valid = s2_valid_q;
    assign out_sof   = s2_sof_q;
    assign out_eol   = s2_eol_q;
    assign out_chan  = s2_chan_q;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;

`ifdef ISP_GAIN_STATS_EN
    logic s1_fend_q, s2_fend_q, out_hs, stat_valid_q, stat_valid_d;
    logic [STAT_W-1:0] acc_r_q, acc_g_q, acc_b_q, acc_r_d, acc_g_d, acc_b_d;
    logic [STAT_W-1:0] stat_r_q, stat_g_q, stat_b_q, stat_r_d, stat_g_d, stat_b_d;
    logic [STAT_W-1:0] sum_r, sum_g, sum_b, pix_ext;

    assign out_hs  = s2_valid_q && out_ready;
    assign pix_ext = STAT_W'(out_pix);

    // out_sof restarts the sums with its own pixel; the last eol of the frame publishes them.
    always_comb begin
        sum_r        = (s2_sof_q ? '0 : acc_r_q) + ((s2_chan_q == CHAN_R) ? pix_ext : '0);
        sum_g        = (s2_sof_q ? '0 : acc_g_q) + ((s2_chan_q == CHAN_G) ? pix_ext : '0);
        sum_b        = (s2_sof_q ? '0 : acc_b_q) + ((s2_chan_q == CHAN_B) ? pix_ext : '0);
        acc_r_d      = acc_r_q;
        acc_g_d      = acc_g_q;
        acc_b_d      = acc_b_q;
        stat_r_d     = stat_r_q;
        stat_g_d     = stat_g_q;
        stat_b_d     = stat_b_q;
        stat_valid_d = 1'b0;
        if (out_hs) begin
            if (s2_fend_q) begin
                stat_r_d     = sum_r;
                stat_g_d     = sum_g;
                stat_b_d     = sum_b;
                stat_valid_d = 1'b1;
                acc_r_d      = '0;
                acc_g_d      = '0;
                acc_b_d      = '0;
            end else begin
                acc_r_d = sum_r;
                acc_g_d = sum_g;
                acc_b_d = sum_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_fend_q    <= 1'b0;
            s2_fend_q    <= 1'b0;
            acc_r_q      <= '0;
            acc_g_q      <= '0;
            acc_b_q      <= '0;
            stat_r_q     <= '0;
            stat_g_q     <= '0;
            stat_b_q     <= '0;
            stat_valid_q <= 1'b0;
        end else begin
            if (accept) s1_fend_q <= line_end && at_last_row;
            if (s2_load) s2_fend_q <= s1_fend_q;
            acc_r_q      <= acc_r_d;
            acc_g_q      <= acc_g_d;
            acc_b_q      <= acc_b_d;
            stat_r_q     <= stat_r_d;
            stat_g_q     <= stat_g_d;
            stat_b_q     <= stat_b_d;
            stat_valid_q <= stat_valid_d;
        end
    end

    assign stat_r     = stat_r_q;
    assign stat_g     = stat_g_q;
    assign stat_b     = stat_b_q;
    assign stat_valid = stat_valid_q;
`else
    assign stat_r     = '0;
    assign stat_g     = '0;
    assign stat_b     = '0;
    assign stat_valid = 1'b0;
`endif

endmodule

// File: tb/tb_isp_gain_stream.sv
// Scoreboard bench for isp_gain_stream on a 4x2 RGGB frame; stats checks
// are active when ISP_GAIN_STATS_EN is defined.
module tb_isp_gain_stream;
    localparam int PIX_W  = 10;
    localparam int GAIN_W = 10;
    localparam int LL     = 4;
    localparam int FL     = 2;
    localparam int STAT_W = PIX_W + $clog2(LL * FL);

    logic clk, rst_n;
    logic in_valid, in_ready, in_sof, in_eol;
    logic [PIX_W-1:0] in_pix;
    logic [GAIN_W-1:0] gain_r, gain_g, gain_b;
    logic out_valid, out_ready, out_sof, out_eol;
    logic [PIX_W-1:0] out_pix;
    logic [1:0] out_chan;
    logic err_short, err_long, stat_valid;
    logic [STAT_W-1:0] stat_r, stat_g, stat_b;

    isp_gain_stream #(
        .PIX_W(PIX_W), .LINE_LENGTH(LL), .FRAME_LINES(FL), .BAYER(0), .GAIN_W(GAIN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_sof(in_sof), .in_eol(in_eol),
        .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .out_sof(out_sof), .out_eol(out_eol), .out_chan(out_chan),
        .err_short(err_short), .err_long(err_long),
        .stat_r(stat_r), .stat_g(stat_g), .stat_b(stat_b), .stat_valid(stat_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pix; bit sof; bit eol; int chan; bit fend; int cyc; bit lat;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit lat_mode = 0;
    int m_col = 0, m_row = 0, m_gr = 256, m_gg = 256, m_gb = 256;
    bit prev_stall = 0;
    logic [14:0] prev_out;
    bit stat_pend = 0;
    longint acc[3];
    longint exp_stat[3];
    int stat_cnt = 0;
    longint last_stat[3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Output monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
            stat_pend  = 0;
            for (int k = 0; k < 3; k++) acc[k] = 0;
        end else begin
`ifdef ISP_GAIN_STATS_EN
            if (stat_pend) begin
                chk("stat_valid_pulse", stat_valid, 1);
                chk("stat_r", stat_r, exp_stat[0]);
                chk("stat_g", stat_g, exp_stat[1]);
                chk("stat_b", stat_b, exp_stat[2]);
                stat_pend = 0;
            end else if (stat_valid) begin
                chk("stat_valid_spurious", stat_valid, 0);
            end
            if (stat_valid) begin
                stat_cnt++;
                last_stat[0] = stat_r; last_stat[1] = stat_g; last_stat[2] = stat_b;
            end
`endif
            if (prev_stall) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_out_stable", {out_pix, out_sof, out_eol, out_chan}, prev_out);
            end
            if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_pix, out_sof, out_eol, out_chan};
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("dup_output", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("out pix=%0d chan=%0d sof=%0d eol=%0d (exp pix=%0d chan=%0d)",
                             out_pix, out_chan, out_sof, out_eol, e.pix, e.chan);
                    chk("out_pix", out_pix, e.pix);
                    chk("out_chan", out_chan, e.chan);
                    chk("out_sof", out_sof, e.sof);
                    chk("out_eol", out_eol, e.eol);
                    if (e.lat) chk("latency", cyc - e.cyc, 2);
`ifdef ISP_GAIN_STATS_EN
                    if (e.sof) for (int k = 0; k < 3; k++) acc[k] = 0;
                    acc[e.chan] += e.pix;
                    if (e.fend) begin
                        for (int k = 0; k < 3; k++) begin
                            exp_stat[k] = acc[k];
                            acc[k] = 0;
                        end
                        stat_pend = 1;
                    end
`else
                    chk("stat_tied_zero", {stat_valid, stat_r, stat_g, stat_b}, 0);
`endif
                end
            end
        end
    end

    // Drives one pixel, models its expected result and pushes it to the scoreboard.
    task automatic send(input int pix, input bit sof, input bit eol);
        exp_t e;
        int cc, cr, g, prod;
        bit last, ok, exp_short, exp_long;
        in_pix = PIX_W'(pix); in_sof = sof; in_eol = eol; in_valid = 1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("in_ready_timeout", in_ready, 1);
            in_valid = 0;
            return;
        end
        cc = sof ? 0 : m_col;
        cr = sof ? 0 : m_row;
        if (sof) begin m_gr = gain_r; m_gg = gain_g; m_gb = gain_b; end
        if (cr % 2 == 0 && cc % 2 == 0)      begin e.chan = 0; g = m_gr; end
        else if (cr % 2 == 1 && cc % 2 == 1) begin e.chan = 2; g = m_gb; end
        else                                 begin e.chan = 1; g = m_gg; end
        prod = (pix * g + 128) >>> 8;
        e.pix = (prod > 1023) ? 1023 : prod;
        last = (cc == LL - 1);
        e.sof = sof;
        e.eol = eol || last;
        e.fend = e.eol && (cr == FL - 1);
        e.cyc = cyc;
        e.lat = lat_mode;
        exp_short = eol && !last;
        exp_long  = !eol && last;
        if (e.eol) begin
            m_col = 0;
            m_row = (cr == FL - 1) ? 0 : cr + 1;
        end else begin
            m_col = cc + 1;
            m_row = cr;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 0; in_sof = 0; in_eol = 0;
        chk("err_short", err_short, exp_short);
        chk("err_long", err_long, exp_long);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_sof = 0; in_eol = 0; in_pix = '0;
        out_ready = 1; gain_r = 10'h100; gain_g = 10'h100; gain_b = 10'h100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_fields", {out_pix, out_sof, out_eol, out_chan}, 0);
        chk("rst_err", {err_short, err_long}, 0);
        chk("rst_stat", {stat_valid, stat_r, stat_g, stat_b}, 0);
        @(posedge clk); #1;
        rst_n = 1;

        // Unity ramp frame with latency checks.
        lat_mode = 1;
        for (int i = 0; i < 8; i++) send(i, i == 0, (i % 4) == 3);
        lat_mode = 0;
        drain();

        // Red gain 2.0: saturation and exact doubling.
        gain_r = 10'h200;
        send(600, 1, 0); send(100, 0, 0); send(300, 0, 0); send(100, 0, 1);
        for (int i = 0; i < 4; i++) send(50 + i, 0, i == 3);
        drain();

        // Gain changes take effect only at the next sof; mid-line sof restarts cleanly.
        gain_r = 10'h100; gain_g = 10'h180; gain_b = 10'h100;
        send(100, 1, 0); send(100, 0, 0);
        gain_g = 10'h080;
        send(100, 0, 0); send(100, 0, 1);
        for (int i = 0; i < 4; i++) send(100, 0, i == 3);
        send(100, 1, 0); send(100, 0, 0); send(100, 0, 0);
        send(7, 1, 0); send(8, 0, 0);
        drain();

        // Backpressure for five cycles mid-line.
        gain_g = 10'h100;
        send(1, 1, 0); send(2, 0, 0);
        out_ready = 0;
        fork
            begin repeat (5) @(posedge clk); #1; out_ready = 1; end
        join_none
        send(3, 0, 0); send(4, 0, 1);
        for (int i = 0; i < 4; i++) send(5 + i, 0, i == 3);
        drain();

        // Short line then long line.
        send(10, 1, 0); send(11, 0, 0); send(12, 0, 1);
        send(13, 0, 0); send(14, 0, 0); send(15, 0, 0); send(16, 0, 0);
        send(17, 0, 0);
        drain();

        // Reset with pixels in flight.
        send(20, 1, 0); send(21, 0, 0);
        rst_n = 0;
        sb.delete();
        m_col = 0; m_row = 0; m_gr = 256; m_gg = 256; m_gb = 256;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1;
        gain_r = 10'h200;
        send(100, 0, 0); send(100, 0, 0);
        drain();

`ifdef ISP_GAIN_STATS_EN
        gain_r = 10'h100;
        stat_cnt = 0;
        for (int i = 0; i < 8; i++) send(10, i == 0, (i % 4) == 3);
        drain();
        chk("stat_pulse_count", stat_cnt, 1);
        chk("stat_r_20", last_stat[0], 20);
        chk("stat_g_40", last_stat[1], 40);
        chk("stat_b_20", last_stat[2], 20);
`else
        chk("stat_off_zero", {stat_valid, stat_r, stat_g, stat_b}, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
